ps2_mouse_rx: RTL and testbench

Parametrised PS/2 mouse packet receiver that deserialises device-to-host frames, validates framing, and assembles 3- or 4-byte movement packets. Decodes buttons, 9-bit signed deltas and the optional wheel nibble, and accumulates a clamped absolute cursor position for the display/GPIO layer. Adds packet-sync recovery, a frame watchdog and error reporting.

---
 rtl/ps2_mouse_rx_if.sv | 27 ++
 rtl/ps2_mouse_rx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 line and decoded-report bundle for ps2_mouse_rx.
// The master side is the receiver. The slave side drives the PS/2 lines and consumes reports.
interface ps2_mouse_rx_if #(
  parameter int COORD_W = 16
);
  logic               ps2_clk;
  logic               ps2_data;
  logic [COORD_W-1:0] x_pos;
  logic [COORD_W-1:0] y_pos;
  logic [8:0]         dx;
  logic [8:0]         dy;
  logic [3:0]         wheel;
  logic [2:0]         btn;
  logic               pkt_valid;
  logic               err_frame;
  logic               err_timeout;

  modport master (
    input  ps2_clk, ps2_data,
    output x_pos, y_pos, dx, dy, wheel, btn, pkt_valid, err_frame, err_timeout
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  x_pos, y_pos, dx, dy, wheel, btn, pkt_valid, err_frame, err_timeout
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: frame deserialiser, packet assembly, decode and clamped position.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_mouse_rx #(
  parameter int PKT_BYTES   = 3,
  parameter int COORD_W     = 16,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  ps2_mouse_rx_if.master bus
);
  localparam int                 WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]         LAST_IDX = 2'(PKT_BYTES - 1);
  localparam logic [COORD_W+1:0] X_HI     = (COORD_W + 2)'(X_MAX);
  localparam logic [COORD_W+1:0] Y_HI     = (COORD_W + 2)'(Y_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t             state_r, state_n;
  logic [2:0]         clk_sync_r;
  logic [1:0]         data_sync_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic [1:0]         idx_r;
  logic [7:0]         buf_r [0:3];
  logic [WD_W-1:0]    wd_r;
  logic [COORD_W-1:0] x_pos_r, y_pos_r;
  logic [8:0]         dx_r, dy_r;
  logic [3:0]         wheel_r;
  logic [2:0]         btn_r;
  logic               pkt_valid_r, err_frame_r, err_timeout_r;
`ifdef PS2_PARITY_CHECK_EN
  logic               par_r;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W+1:0] v,
                                               input logic [COORD_W+1:0] hi);
    if (v[COORD_W+1]) return '0;
    else if (v > hi)  return hi[COORD_W-1:0];
    else              return v[COORD_W-1:0];
  endfunction

  logic strobe, bit_in, frame_done, frame_ok, timeout_s;
  logic sync_bad, store, last, err_frame_s;
  logic [7:0] b1, b2;
  logic [8:0] dx_n, dy_n;
  logic [3:0] wheel_n;
  logic [COORD_W+1:0] x_step, y_step, x_sum, y_sum;

  assign strobe = clk_sync_r[2] & ~clk_sync_r[1];
  assign bit_in = data_sync_r[1];

  // Two-flop synchronisers plus the previous-clock flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 3'b000;
      data_sync_r <= 2'b00;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[0], bus.ps2_data};
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  // Frame next-state, byte completion and watchdog abort
  always_comb begin
    state_n    = state_r;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    timeout_s  = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else if (strobe) begin
      case (state_r)
        IDLE:    state_n = bit_in ? IDLE : DATA;
        DATA:    state_n = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n    = IDLE;
          frame_done = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          frame_ok   = bit_in & odd_parity_ok(shift_r, par_r);
`else
          frame_ok   = bit_in;
`endif
        end
        default: state_n = IDLE;
      endcase
    end else if ((wd_r == WD_LAST) && ((state_r != IDLE) || (idx_r != 2'd0))) begin
      state_n   = IDLE;
      timeout_s = 1'b1;
    end else begin
      state_n = state_r;
    end
  end

  assign sync_bad    = frame_done & frame_ok & (idx_r == 2'd0) & ~shift_r[3];
  assign store       = frame_done & frame_ok & ~sync_bad;
  assign last        = store & (idx_r == LAST_IDX);
  assign err_frame_s = frame_done & (~frame_ok | sync_bad);

  // The final byte is still in the shift register when the packet completes
  assign b1      = buf_r[1];
  assign b2      = (PKT_BYTES == 3) ? shift_r : buf_r[2];
  assign wheel_n = (PKT_BYTES == 4) ? shift_r[3:0] : 4'd0;
  assign dx_n    = {buf_r[0][4], b1};
  assign dy_n    = {buf_r[0][5], b2};
  assign x_step  = buf_r[0][6] ? '0 : {{(COORD_W - 7){dx_n[8]}}, dx_n};
  assign y_step  = buf_r[0][7] ? '0 : {{(COORD_W - 7){dy_n[8]}}, dy_n};
  assign x_sum   = {2'b00, x_pos_r} + x_step;
  assign y_sum   = {2'b00, y_pos_r} - y_step;

  // Bit shifter, byte index, packet buffer and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      idx_r     <= 2'd0;
      wd_r      <= '0;
      for (int i = 0; i < 4; i++) buf_r[i] <= 8'd0;
`ifdef PS2_PARITY_CHECK_EN
      par_r     <= 1'b0;
`endif
    end else if (!en) begin
      bit_cnt_r <= 3'd0;
      idx_r     <= 2'd0;
      wd_r      <= '0;
    end else begin
      if (strobe || timeout_s)                         wd_r <= '0;
      else if ((state_r != IDLE) || (idx_r != 2'd0))   wd_r <= wd_r + 1'b1;
      else                                             wd_r <= '0;
      if (strobe) begin
        case (state_r)
          IDLE: bit_cnt_r <= 3'd0;
          DATA: begin
            shift_r   <= {bit_in, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par_r <= bit_in;
`endif
          default: ;
        endcase
      end
      if (timeout_s)                  idx_r <= 2'd0;
      else if (frame_done && !frame_ok) idx_r <= 2'd0;
      else if (store)                 idx_r <= last ? 2'd0 : idx_r + 2'd1;
      if (store) buf_r[idx_r] <= shift_r;
    end
  end

  // Registered decode, accumulation and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos_r <= '0;  y_pos_r <= '0;
      dx_r    <= 9'd0; dy_r <= 9'd0;
      wheel_r <= 4'd0; btn_r <= 3'd0;
      pkt_valid_r <= 1'b0; err_frame_r <= 1'b0; err_timeout_r <= 1'b0;
    end else begin
      pkt_valid_r   <= last;
      err_frame_r   <= err_frame_s;
      err_timeout_r <= timeout_s;
      if (last) begin
        btn_r   <= buf_r[0][2:0];
        dx_r    <= dx_n;
        dy_r    <= dy_n;
        wheel_r <= wheel_n;
        x_pos_r <= clamp(x_sum, X_HI);
        y_pos_r <= clamp(y_sum, Y_HI);
      end
    end
  end

  assign bus.x_pos       = x_pos_r;
  assign bus.y_pos       = y_pos_r;
  assign bus.dx          = dx_r;
  assign bus.dy          = dy_r;
  assign bus.wheel       = wheel_r;
  assign bus.btn         = btn_r;
  assign bus.pkt_valid   = pkt_valid_r;
  assign bus.err_frame   = err_frame_r;
  assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench: a 3-byte and a 4-byte receiver share one PS/2 stream and are
// compared against a packet-level reference model after every frame.
module tb_ps2_mouse_rx;
  localparam int TMO = 300;
  localparam int H   = 8;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic ps2_clk = 1'b1, ps2_data = 1'b1;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  ps2_mouse_rx_if #(.COORD_W(16)) if3 ();
  ps2_mouse_rx_if #(.COORD_W(16)) if4 ();
  assign if3.ps2_clk = ps2_clk;  assign if3.ps2_data = ps2_data;
  assign if4.ps2_clk = ps2_clk;  assign if4.ps2_data = ps2_data;

  ps2_mouse_rx #(.PKT_BYTES(3), .COORD_W(16), .X_MAX(639), .Y_MAX(479), .TIMEOUT_CYC(TMO))
    dut3 (.clk(clk), .rst(rst), .en(en), .bus(if3));
  ps2_mouse_rx #(.PKT_BYTES(4), .COORD_W(16), .X_MAX(639), .Y_MAX(479), .TIMEOUT_CYC(TMO))
    dut4 (.clk(clk), .rst(rst), .en(en), .bus(if4));

  // Pulse counters observed away from the active edge
  int pv_cnt [2], ef_cnt [2], et_cnt [2], excl_bad;
  initial begin
    for (int k = 0; k < 2; k++) begin pv_cnt[k] = 0; ef_cnt[k] = 0; et_cnt[k] = 0; end
    excl_bad = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      pv_cnt[0] <= pv_cnt[0] + int'(if3.pkt_valid);
      ef_cnt[0] <= ef_cnt[0] + int'(if3.err_frame);
      et_cnt[0] <= et_cnt[0] + int'(if3.err_timeout);
      pv_cnt[1] <= pv_cnt[1] + int'(if4.pkt_valid);
      ef_cnt[1] <= ef_cnt[1] + int'(if4.err_frame);
      et_cnt[1] <= et_cnt[1] + int'(if4.err_timeout);
      if ($countones({if3.pkt_valid, if3.err_frame, if3.err_timeout}) > 1 ||
          $countones({if4.pkt_valid, if4.err_frame, if4.err_timeout}) > 1)
        excl_bad <= excl_bad + 1;
    end
  end

  // Reference model state, one entry per receiver (0: 3-byte, 1: 4-byte)
  int       m_idx [2], m_x [2], m_y [2], m_dx [2], m_dy [2], m_wh [2], m_btn [2];
  int       m_pv [2], m_ef [2], m_et [2];
  int       m_buf [2][4];
  bit       m_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_frame(input int b, input bit bad_stop, input bit bad_par);
    bit ok = !bad_stop;
    int pk, b0, dxs, dys;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) ok = 1'b0;
`endif
    if (!m_en) return;
    for (int k = 0; k < 2; k++) begin
      pk = (k == 0) ? 3 : 4;
      if (!ok) begin
        m_ef[k]++; m_idx[k] = 0;
      end else if (m_idx[k] == 0 && ((b / 8) % 2) == 0) begin
        m_ef[k]++;
      end else begin
        m_buf[k][m_idx[k]] = b;
        m_idx[k]++;
        if (m_idx[k] == pk) begin
          m_idx[k] = 0;
          m_pv[k]++;
          b0 = m_buf[k][0];
          m_btn[k] = b0 % 8;
          m_dx[k]  = ((b0 >> 4) % 2) * 256 + m_buf[k][1];
          m_dy[k]  = ((b0 >> 5) % 2) * 256 + m_buf[k][2];
          m_wh[k]  = (pk == 4) ? m_buf[k][3] % 16 : 0;
          dxs = (m_dx[k] >= 256) ? m_dx[k] - 512 : m_dx[k];
          dys = (m_dy[k] >= 256) ? m_dy[k] - 512 : m_dy[k];
          if (((b0 >> 6) % 2) == 0) m_x[k] = clampi(m_x[k] + dxs, 639);
          if (((b0 >> 7) % 2) == 0) m_y[k] = clampi(m_y[k] - dys, 479);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " k3 pv"},    pv_cnt[0],   m_pv[0]);
    check_eq({tag, " k3 ef"},    ef_cnt[0],   m_ef[0]);
    check_eq({tag, " k3 et"},    et_cnt[0],   m_et[0]);
    check_eq({tag, " k3 x"},     if3.x_pos,   m_x[0]);
    check_eq({tag, " k3 y"},     if3.y_pos,   m_y[0]);
    check_eq({tag, " k3 dx"},    if3.dx,      m_dx[0]);
    check_eq({tag, " k3 dy"},    if3.dy,      m_dy[0]);
    check_eq({tag, " k3 btn"},   if3.btn,     m_btn[0]);
    check_eq({tag, " k3 wheel"}, if3.wheel,   m_wh[0]);
    check_eq({tag, " k4 pv"},    pv_cnt[1],   m_pv[1]);
    check_eq({tag, " k4 ef"},    ef_cnt[1],   m_ef[1]);
    check_eq({tag, " k4 et"},    et_cnt[1],   m_et[1]);
    check_eq({tag, " k4 x"},     if4.x_pos,   m_x[1]);
    check_eq({tag, " k4 y"},     if4.y_pos,   m_y[1]);
    check_eq({tag, " k4 dx"},    if4.dx,      m_dx[1]);
    check_eq({tag, " k4 dy"},    if4.dy,      m_dy[1]);
    check_eq({tag, " k4 btn"},   if4.btn,     m_btn[1]);
    check_eq({tag, " k4 wheel"}, if4.wheel,   m_wh[1]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par, input string tag);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_clk(H);
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(12);
    model_frame(int'(b), bad_stop, bad_par);
    check_all(tag);
  endtask

  task automatic stall(input string tag);
    wait_clk(TMO + 40);
    for (int k = 0; k < 2; k++)
      if (m_en && m_idx[k] != 0) begin m_et[k]++; m_idx[k] = 0; end
    check_all(tag);
  endtask

  task automatic set_en(input bit v);
    en = v;
    wait_clk(3);
    m_en = v;
    if (!v) for (int k = 0; k < 2; k++) m_idx[k] = 0;
  endtask

  task automatic resync();
    if (m_idx[0] != 0 || m_idx[1] != 0) stall("resync");
  endtask

  initial begin
    int r;
    logic [7:0] rb;
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dx[k] = 0; m_dy[k] = 0;
      m_wh[k] = 0; m_btn[k] = 0; m_pv[k] = 0; m_ef[k] = 0; m_et[k] = 0;
      for (int j = 0; j < 4; j++) m_buf[k][j] = 0;
    end
    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);
    check_all("reset");
    check_eq("reset pv3 level", if3.pkt_valid, 0);

    send_frame(8'h09, 0, 0, "tp1");
    send_frame(8'h0A, 0, 0, "tp1");
    send_frame(8'h00, 0, 0, "tp1");
    check_eq("tp1 x10", if3.x_pos, 10);
    check_eq("tp1 dx10", if3.dx, 10);
    check_eq("tp1 btn", if3.btn, 1);

    send_frame(8'h28, 0, 0, "tp2"); send_frame(8'h05, 0, 0, "tp2"); send_frame(8'hF6, 0, 0, "tp2");
    check_eq("tp2 x15", if3.x_pos, 15);
    check_eq("tp2 y10", if3.y_pos, 10);
    check_eq("tp2 dy", if3.dy, 9'h1F6);
    send_frame(8'h18, 0, 0, "tp2b"); send_frame(8'hE0, 0, 0, "tp2b"); send_frame(8'h00, 0, 0, "tp2b");
    check_eq("tp2 xclamp", if3.x_pos, 0);

    send_frame(8'h00, 0, 0, "tp3 sync");
    send_frame(8'h08, 0, 0, "tp3"); send_frame(8'h01, 0, 0, "tp3"); send_frame(8'h01, 0, 0, "tp3");

    resync();
    send_frame(8'h08, 0, 0, "tp4");
    stall("tp4 stall");
    send_frame(8'h09, 0, 0, "tp4"); send_frame(8'h03, 0, 0, "tp4"); send_frame(8'h02, 0, 0, "tp4");

    send_frame(8'h08, 1, 0, "tp5 stop");
    send_frame(8'h08, 0, 1, "tp5 par");

    resync();
    send_frame(8'h08, 0, 0, "tp6"); send_frame(8'h00, 0, 0, "tp6");
    send_frame(8'h00, 0, 0, "tp6"); send_frame(8'h0F, 0, 0, "tp6");
    check_eq("tp6 wheel", if4.wheel, 4'hF);
    send_frame(8'h0C, 0, 0, "tp6 en");
    set_en(1'b0);
    send_frame(8'h0A, 0, 0, "tp6 en off");
    set_en(1'b1);
    check_all("tp6 en back");

    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 99);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) != 0) rb[3] = 1'b1;
      if (r < 4) stall("rnd stall");
      else if (r < 7) begin
        set_en(1'b0);
        send_frame(rb, 0, 0, "rnd en off");
        set_en(1'b1);
      end
      else send_frame(rb, (r >= 7 && r < 12), (r >= 12 && r < 17), "rnd");
    end

    check_eq("pulse exclusivity", excl_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
